// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader
// Purpose : Streams instruction words into an instruction memory. A start
//           request latches a base address and a word count; each accepted
//           word is written one cycle later at an incrementing (modulo DEPTH)
//           address while a running XOR checksum is kept. Loads can be
//           aborted or discarded by reset.
// Ports   :
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle load request (honoured in IDLE only)
//   abort      - cancel the load in progress (honoured in LOAD only)
//   base_addr  - first write address, sampled on an accepted start
//   length     - word count 0..DEPTH, sampled on an accepted start
//   in_valid   - in_data holds a word
//   in_data    - instruction word
//   in_ready   - a word is accepted this cycle if in_valid is high
//   mem_we     - memory write enable (one cycle after acceptance)
//   mem_waddr  - memory write address
//   mem_wdata  - memory write data
//   busy       - load in progress (LOAD or FINISH)
//   done       - one-cycle completion pulse
//   wrapped    - write pointer passed DEPTH-1 during this load
//   checksum   - XOR of all words accepted in this load
// Revision: 1.0 - initial release
// ============================================================================
module prog_loader #(
   parameter int W          = 9,
   parameter int DEPTH      = 512,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   length,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [W-1:0]  mem_wdata,
   output logic          busy,
   output logic          done,
   output logic          wrapped,
   output logic [W-1:0]  checksum
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

   state_t        r_state;
   logic [AW-1:0] r_ptr;
   logic [AW:0]   r_remain;
   logic          r_in_ready;
   logic          r_busy;
   logic          r_done;
   logic          r_wrapped;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_waddr;
   logic [W-1:0]  r_mem_wdata;
   logic [W-1:0]  r_checksum;

   logic          w_accept;
   logic          w_ptr_at_last;

   assign w_accept      = in_valid && r_in_ready;
   assign w_ptr_at_last = (r_ptr == c_LAST_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_remain    <= '0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wrapped   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_checksum  <= '0;
      end else begin
         // Write strobe and done are single-cycle unless re-asserted below.
         r_mem_we <= 1'b0;
         r_done   <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ptr      <= base_addr;
                  r_remain   <= length;
                  r_checksum <= '0;
                  r_wrapped  <= 1'b0;
                  r_busy     <= 1'b1;
                  if (length == '0) begin
                     // Empty load: straight to completion, nothing written.
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_LOAD;
                     r_in_ready <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               if (w_accept) begin
                  r_mem_we    <= 1'b1;
                  r_mem_waddr <= r_ptr;
                  r_mem_wdata <= in_data;
                  r_checksum  <= r_checksum ^ in_data;
                  r_remain    <= r_remain - 1'b1;
                  if (w_ptr_at_last) begin
                     r_ptr     <= '0;
                     r_wrapped <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + 1'b1;
                  end
               end

               // Abort wins over completion on the final beat; a beat taken
               // in the abort cycle still gets its write issued above.
               if (abort) begin
                  r_state    <= S_IDLE;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
               end else if (w_accept && (r_remain == (AW+1)'(1))) begin
                  r_state    <= S_FINISH;
                  r_in_ready <= 1'b0;
                  r_done     <= 1'b1;
               end
            end

            S_FINISH: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end

            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign mem_we    = r_mem_we;
   assign mem_waddr = r_mem_waddr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;
   assign done      = r_done;
   assign wrapped   = r_wrapped;
   assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_loader
// Purpose : Directed self-checking bench for prog_loader (W=9, DEPTH=512).
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_loader;

   localparam int W  = 9;
   localparam int AW = 9;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [W-1:0]  mem_wdata;
   logic          busy;
   logic          done;
   logic          wrapped;
   logic [W-1:0]  checksum;

   int checks = 0;
   int errors = 0;

   prog_loader #(.W(W), .DEPTH(512)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .length    (length),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .wrapped   (wrapped),
      .checksum  (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_write(input string tag, input logic [AW-1:0] a, input logic [W-1:0] d);
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      chk({tag, "_addr"}, 32'(mem_waddr), 32'(a));
      chk({tag, "_data"}, 32'(mem_wdata), 32'(d));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_wrapped"}, 32'(wrapped), 32'd0);
      chk({tag, "_checksum"}, 32'(checksum), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      base_addr = '0;
      length    = '0;
      in_valid  = 1'b0;
      in_data   = '0;

      // ---------------- reset state ----------------
      #2;
      chk_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // ---------------- basic 3-word load ----------------
      start = 1'b1; base_addr = 9'h010; length = 10'd3;
      tick();
      start = 1'b0;
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ready", 32'(in_ready), 32'd1);
      chk("t1_no_we", 32'(mem_we), 32'd0);
      in_valid = 1'b1; in_data = 9'h1A5;
      tick();
      chk_write("t1_w0", 9'h010, 9'h1A5);
      chk("t1_w0_done", 32'(done), 32'd0);
      in_data = 9'h003;
      tick();
      chk_write("t1_w1", 9'h011, 9'h003);
      in_data = 9'h100;
      tick();
      chk_write("t1_w2", 9'h012, 9'h100);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_ready_off", 32'(in_ready), 32'd0);
      chk("t1_busy_fin", 32'(busy), 32'd1);
      chk("t1_checksum", 32'(checksum), 32'h0A6);
      chk("t1_wrapped", 32'(wrapped), 32'd0);
      in_valid = 1'b0;
      tick();
      chk("t1_idle_busy", 32'(busy), 32'd0);
      chk("t1_idle_done", 32'(done), 32'd0);
      chk("t1_idle_we", 32'(mem_we), 32'd0);
      chk("t1_idle_cks", 32'(checksum), 32'h0A6);

      // ---------------- wrap-around load ----------------
      start = 1'b1; base_addr = 9'h1FE; length = 10'd4;
      tick();
      start = 1'b0;
      chk("t2_cks_clr", 32'(checksum), 32'd0);
      in_valid = 1'b1; in_data = 9'h001;
      tick();
      chk_write("t2_w0", 9'h1FE, 9'h001);
      chk("t2_w0_wrap", 32'(wrapped), 32'd0);
      in_data = 9'h002;
      tick();
      chk_write("t2_w1", 9'h1FF, 9'h002);
      in_data = 9'h004;
      tick();
      chk_write("t2_w2", 9'h000, 9'h004);
      in_data = 9'h008;
      tick();
      chk_write("t2_w3", 9'h001, 9'h008);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_wrapped", 32'(wrapped), 32'd1);
      chk("t2_checksum", 32'(checksum), 32'h00F);
      in_valid = 1'b0;
      tick();
      chk("t2_wrap_hold", 32'(wrapped), 32'd1);

      // ---------------- zero-length load ----------------
      start = 1'b1; base_addr = 9'h055; length = 10'd0;
      tick();
      start = 1'b0;
      chk("t3_busy", 32'(busy), 32'd1);
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_we", 32'(mem_we), 32'd0);
      chk("t3_ready", 32'(in_ready), 32'd0);
      tick();
      chk("t3_idle_busy", 32'(busy), 32'd0);
      chk("t3_idle_done", 32'(done), 32'd0);
      chk("t3_idle_we", 32'(mem_we), 32'd0);
      chk("t3_idle_ready", 32'(in_ready), 32'd0);

      // ---------------- gapped load ----------------
      start = 1'b1; base_addr = 9'h020; length = 10'd2;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 9'h0AA;
      tick();
      chk_write("t4_w0", 9'h020, 9'h0AA);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_gap_we", 32'(mem_we), 32'd0);
         chk("t4_gap_busy", 32'(busy), 32'd1);
         chk("t4_gap_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1; in_data = 9'h055;
      tick();
      chk_write("t4_w1", 9'h021, 9'h055);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_checksum", 32'(checksum), 32'h0FF);
      in_valid = 1'b0;
      tick();
      chk("t4_after_done", 32'(done), 32'd0);
      chk("t4_after_we", 32'(mem_we), 32'd0);

      // ---------------- abort with second beat ----------------
      start = 1'b1; base_addr = 9'h100; length = 10'd4;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 9'h011;
      tick();
      chk_write("t5_w0", 9'h100, 9'h011);
      in_data = 9'h022; abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_write("t5_w1", 9'h101, 9'h022);
      chk("t5_no_done", 32'(done), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_ready", 32'(in_ready), 32'd0);
      in_data = 9'h033;
      tick();
      chk("t5_no_more_we", 32'(mem_we), 32'd0);
      chk("t5_no_done2", 32'(done), 32'd0);
      in_valid = 1'b0;
      start = 1'b1; base_addr = 9'h030; length = 10'd1;
      tick();
      start = 1'b0;
      chk("t5_restart_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = 9'h1FF;
      tick();
      chk_write("t5_rw", 9'h030, 9'h1FF);
      chk("t5_rdone", 32'(done), 32'd1);
      chk("t5_rcks", 32'(checksum), 32'h1FF);
      in_valid = 1'b0;
      tick();

      // ---------------- reset mid-load ----------------
      start = 1'b1; base_addr = 9'h040; length = 10'd3;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 9'h077;
      tick();
      chk_write("t6_w0", 9'h040, 9'h077);
      in_data = 9'h088;
      rst_n = 1'b0;
      #1;
      chk_all_zero("t6_rst");
      tick();
      chk("t6_rst_we", 32'(mem_we), 32'd0);
      #2;
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("t6_post_we", 32'(mem_we), 32'd0);
      chk("t6_post_busy", 32'(busy), 32'd0);
      start = 1'b1; base_addr = 9'h0C0; length = 10'd1;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_data = 9'h123;
      tick();
      chk_write("t6_rw", 9'h0C0, 9'h123);
      chk("t6_rdone", 32'(done), 32'd1);
      chk("t6_rcks", 32'(checksum), 32'h123);
      in_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
